decoded_bits_unloader: RTL

- Reader side of the decoded-bits shift buffer.
- When the decoder finishes a frame, the buffer presents all N decoded hard bits in parallel. This block captures them into a shadow register so the buffer is free for the next frame.
- It then streams the frame out as N/W words of W bits over a valid/ready interface, with a last-word marker and an overrun flag.
- It sits between the SCAN decoder core and the downstream consumer (host FIFO or AXI-stream bridge).

---
 rtl/decoded_bits_unloader_if.sv | 29 ++
 rtl/decoded_bits_unloader.sv | 65 ++++++
 2 files changed

// File: rtl/decoded_bits_unloader_if.sv
// decoded_bits_unloader_if: frame capture and word stream signals between decoder, unloader and consumer
// Ports (slave = unloader view):
//   I_frame_valid/I_frame_bits  frame pulse and parallel decoded bits from the decoder
//   O_frame_ready               unloader idle, a frame pulse will be captured
//   O_data/O_valid/I_ready      W-bit valid/ready word stream to the consumer
//   O_last                      final word of the frame
//   O_busy/O_overrun            streaming status and sticky dropped-frame error
interface decoded_bits_unloader_if #(
  parameter int N = 1024,
  parameter int W = 8
);
  logic         I_frame_valid;
  logic [N-1:0] I_frame_bits;
  logic         O_frame_ready;
  logic [W-1:0] O_data;
  logic         O_valid;
  logic         I_ready;
  logic         O_last;
  logic         O_busy;
  logic         O_overrun;
  modport master (
    output I_frame_valid, I_frame_bits, I_ready,
    input  O_frame_ready, O_data, O_valid, O_last, O_busy, O_overrun
  );
  modport slave (
    input  I_frame_valid, I_frame_bits, I_ready,
    output O_frame_ready, O_data, O_valid, O_last, O_busy, O_overrun
  );
endinterface

// File: rtl/decoded_bits_unloader.sv
// decoded_bits_unloader: captures a decoded N-bit frame into a shadow register and streams it out as N/W words of W bits
// Ports: clk, rst (sync active-high), bus (decoded_bits_unloader_if.slave).
// Build option DBU_BITREV_EN: store the frame bit-reversed over log2(N) index bits so words come out in natural info-bit order.
module decoded_bits_unloader #(
  parameter int N = 1024,
  parameter int W = 8
) (
  input logic clk,
  input logic rst,
  decoded_bits_unloader_if.slave bus
);
  localparam int NW = N / W;
  localparam int CW = NW > 1 ? $clog2(NW) : 1;
  localparam logic [CW-1:0] LAST = CW'(NW - 1);
  typedef enum logic {IDLE, SEND} state_t;
  state_t        state;
  logic [CW-1:0] cnt;
  logic [N-1:0]  r_frame;
  logic [N-1:0]  cap;
  logic          overrun;
  logic          last;
`ifdef DBU_BITREV_EN
  localparam int LG = $clog2(N);
  function automatic int bitrev(input int p);
    int r;
    r = 0;
    for (int k = 0; k < LG; k++) r[k] = p[LG-1-k];
    return r;
  endfunction
  // Pure wiring: the permutation is applied on the way into r_frame.
  for (genvar i = 0; i < N; i++) begin : g_rev
    assign cap[i] = bus.I_frame_bits[bitrev(i)];
  end
`else
  assign cap = bus.I_frame_bits;
`endif
  assign last              = (state == SEND) && (cnt == LAST);
  assign bus.O_valid       = state == SEND;
  assign bus.O_busy        = state == SEND;
  assign bus.O_frame_ready = state == IDLE;
  assign bus.O_last        = last;
  assign bus.O_overrun     = overrun;
  assign bus.O_data        = r_frame[cnt*W +: W];
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      r_frame <= '0;
      overrun <= 1'b0;
    end else if (state == IDLE) begin
      if (bus.I_frame_valid) begin
        r_frame <= cap;
        cnt     <= '0;
        state   <= SEND;
      end
    end else begin
      // A frame offered while streaming is dropped; only the flag records it.
      if (bus.I_frame_valid) overrun <= 1'b1;
      if (bus.I_ready) begin
        cnt   <= last ? '0 : cnt + 1'b1;
        state <= last ? IDLE : SEND;
      end
    end
  end
endmodule
